// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution post-processing path.
// Holds the requantize/saturate function used by conv_y_requant.
package conv_pkg;

  localparam int unsigned ACC_SIZE  = 21;
  localparam int unsigned OUT_WIDTH = 8;
  localparam int unsigned X_SIZE    = 128;
  localparam int unsigned F_SIZE    = 32;
  localparam int unsigned Y_COUNT   = X_SIZE - F_SIZE + 1;

  localparam logic signed [ACC_SIZE:0] SatMax = (ACC_SIZE + 1)'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_SIZE:0] SatMin = (ACC_SIZE + 1)'(-(1 << (OUT_WIDTH - 1)));

  typedef struct packed {
    logic signed [OUT_WIDTH-1:0] data;
    logic                        sat;
    logic                        last;
  } y_entry_t;

  // Round-half-up shift in ACC_SIZE+1 bits so the rounding add cannot overflow.
  function automatic y_entry_t requant(input logic signed [ACC_SIZE-1:0] y,
                                       input int unsigned               shift,
                                       input logic                      relu_en,
                                       input logic                      last);
    logic signed [ACC_SIZE:0] ext;
    logic signed [ACC_SIZE:0] rnd;
    logic signed [ACC_SIZE:0] r;
    y_entry_t                 e;
    ext = {y[ACC_SIZE-1], y};
    rnd = '0;
    if (shift != 0) rnd = (ACC_SIZE + 1)'(1) << (shift - 1);
    r = (ext + rnd) >>> shift;
    if (relu_en && (r < 0)) r = '0;
    e.sat  = 1'b0;
    e.last = last;
    if (r > SatMax) begin
      r     = SatMax;
      e.sat = 1'b1;
    end else if (r < SatMin) begin
      r     = SatMin;
      e.sat = 1'b1;
    end
    e.data = OUT_WIDTH'(r);
    return e;
  endfunction

endpackage

// File: rtl/conv_y_requant_if.sv
// Handshake bundle for conv_y_requant: accumulator input stream and requantized output stream.
interface conv_y_requant_if;
  import conv_pkg::*;

  logic                        s_valid_y;
  logic                        s_ready_y;
  logic signed [ACC_SIZE-1:0]  s_data_in_y;
  logic                        m_valid_z;
  logic                        m_ready_z;
  logic signed [OUT_WIDTH-1:0] m_data_out_z;
  logic                        m_sat_z;
  logic                        m_last_z;

  modport slave (
    input  s_valid_y, s_data_in_y, m_ready_z,
    output s_ready_y, m_valid_z, m_data_out_z, m_sat_z, m_last_z
  );

  modport master (
    output s_valid_y, s_data_in_y, m_ready_z,
    input  s_ready_y, m_valid_z, m_data_out_z, m_sat_z, m_last_z
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; read port presents the head entry from storage flops.
module sync_fifo #(
  parameter type         entry_t = logic [7:0],
  parameter int unsigned DEPTH   = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   wr_en,
  input  entry_t wr_data,
  input  logic   rd_en,
  output entry_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            do_wr;
  logic            do_rd;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  // No write-through: a full FIFO refuses writes even when a read happens this cycle.
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_wr != do_rd) count_q <= do_wr ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

endmodule

// File: rtl/conv_y_requant.sv
// Requantizes the conv core accumulator stream to 8 bits and flags the last sample of each frame.
// Define CONV_Y_RELU_EN to clamp negative results to zero before saturation.
module conv_y_requant
  import conv_pkg::*;
#(
  parameter int unsigned SHIFT = 6,
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  conv_y_requant_if.slave bus
);

`ifdef CONV_Y_RELU_EN
  localparam logic ReluEn = 1'b1;
`else
  localparam logic ReluEn = 1'b0;
`endif

  localparam int unsigned IdxW = $clog2(Y_COUNT);

  logic [IdxW-1:0] idx_q;
  logic            idx_last;
  logic            accept;
  logic            full;
  logic            empty;
  y_entry_t        wr_entry;
  y_entry_t        rd_entry;

  assign idx_last       = (idx_q == IdxW'(Y_COUNT - 1));
  assign accept         = bus.s_valid_y & ~full;
  assign wr_entry       = requant(bus.s_data_in_y, SHIFT, ReluEn, idx_last);

  assign bus.s_ready_y    = ~full;
  assign bus.m_valid_z    = ~empty;
  assign bus.m_data_out_z = rd_entry.data;
  assign bus.m_sat_z      = rd_entry.sat;
  assign bus.m_last_z     = rd_entry.last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= idx_last ? '0 : idx_q + 1'b1;
    end
  end

  sync_fifo #(
    .entry_t (y_entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.s_valid_y),
    .wr_data (wr_entry),
    .rd_en   (bus.m_ready_z),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_conv_y_requant.sv
// Directed bench for conv_y_requant with SHIFT=6, DEPTH=4; expectations are hand-computed.
module tb_conv_y_requant;
  import conv_pkg::*;

`ifdef CONV_Y_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  conv_y_requant_if bus ();

  conv_y_requant #(
    .SHIFT (6),
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_z(input int v);
    return (Relu && v < 0) ? 0 : v;
  endfunction

  function automatic int exp_s(input int v, input int s);
    return (Relu && v < 0) ? 0 : s;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    bus.s_valid_y = 1'b0;
    bus.m_ready_z = 1'b0;
    bus.s_data_in_y = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Single sample into an empty FIFO: visible one edge later, then drained.
  task automatic one(input string tag, input int y, input int z, input int s);
    bus.m_ready_z = 1'b0;
    bus.s_valid_y = 1'b1;
    bus.s_data_in_y = ACC_SIZE'(y);
    @(posedge clk); #1;
    bus.s_valid_y = 1'b0;
    chk({tag, "_valid"}, 32'(bus.m_valid_z), 1);
    chk({tag, "_z"}, 32'(bus.m_data_out_z), exp_z(z));
    chk({tag, "_sat"}, 32'(bus.m_sat_z), exp_s(z, s));
    bus.m_ready_z = 1'b1;
    @(posedge clk); #1;
    bus.m_ready_z = 1'b0;
    chk({tag, "_drain"}, 32'(bus.m_valid_z), 0);
  endtask

  // Sample i = i*64 -> z = min(i,127); last on every 97th sample since reset.
  task automatic stream(input string tag, input int n);
    bus.m_ready_z = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.s_valid_y = 1'b1;
      bus.s_data_in_y = ACC_SIZE'(i * 64);
      @(posedge clk); #1;
      chk({tag, "_valid"}, 32'(bus.m_valid_z), 1);
      chk({tag, "_ready"}, 32'(bus.s_ready_y), 1);
      chk({tag, "_z"}, 32'(bus.m_data_out_z), (i > 127) ? 127 : i);
      chk({tag, "_sat"}, 32'(bus.m_sat_z), (i > 127) ? 1 : 0);
      chk({tag, "_last"}, 32'(bus.m_last_z), ((i % 97) == 96) ? 1 : 0);
    end
    bus.s_valid_y = 1'b0;
    @(posedge clk); #1;
    bus.m_ready_z = 1'b0;
    chk({tag, "_empty"}, 32'(bus.m_valid_z), 0);
  endtask

  int vy [14] = '{100, -100, 32, 31, -32, -33, 20000, -20000,
                  8159, 8160, -8224, -8225, 1048575, -1048576};
  int vz [14] = '{2, -2, 1, 0, 0, -1, 127, -128, 127, 127, -128, -128, 127, -128};
  int vs [14] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1};

  int q_z[$];
  int q_s[$];
  int q_l[$];

  initial begin
    int sent, got, cyc, nacc, k, hz, hs, hl, ez, es;
    bit stalled;

    do_reset();
    chk("rst_valid", 32'(bus.m_valid_z), 0);
    chk("rst_z", 32'(bus.m_data_out_z), 0);
    chk("rst_sat", 32'(bus.m_sat_z), 0);
    chk("rst_last", 32'(bus.m_last_z), 0);
    chk("rst_ready", 32'(bus.s_ready_y), 1);

    for (int i = 0; i < 14; i++) one($sformatf("vec%0d", i), vy[i], vz[i], vs[i]);

    do_reset();
    stream("frame2", 2 * Y_COUNT);

    // Backpressure: four accepts fill the FIFO, fifth and sixth are refused.
    do_reset();
    for (int j = 0; j < 6; j++) begin
      bus.s_valid_y = 1'b1;
      bus.s_data_in_y = ACC_SIZE'((10 + j) * 64);
      chk("bp_ready", 32'(bus.s_ready_y), (j < 4) ? 1 : 0);
      @(posedge clk); #1;
    end
    bus.s_valid_y = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold_valid", 32'(bus.m_valid_z), 1);
    chk("bp_hold_z", 32'(bus.m_data_out_z), 10);
    chk("bp_full_ready", 32'(bus.s_ready_y), 0);
    bus.m_ready_z = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("bp_out_valid", 32'(bus.m_valid_z), 1);
      chk("bp_out_z", 32'(bus.m_data_out_z), 10 + j);
      @(posedge clk); #1;
      if (j == 0) chk("bp_ready_back", 32'(bus.s_ready_y), 1);
    end
    chk("bp_empty", 32'(bus.m_valid_z), 0);
    bus.m_ready_z = 1'b0;

    // Random valid/ready with k*64+r inputs, so z is simply k clamped.
    do_reset();
    sent = 0; got = 0; cyc = 0; nacc = 0; stalled = 1'b0;
    hz = 0; hs = 0; hl = 0;
    while (got < 1000 && cyc < 20000) begin
      k = int'($urandom_range(0, 260)) - 130;
      bus.s_valid_y = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bus.s_data_in_y = ACC_SIZE'(k * 64 + int'($urandom_range(0, 31)));
      bus.m_ready_z = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (stalled) begin
        chk("rnd_stable_z", 32'(bus.m_data_out_z), hz);
        chk("rnd_stable_sat", 32'(bus.m_sat_z), hs);
        chk("rnd_stable_last", 32'(bus.m_last_z), hl);
      end
      if (bus.s_valid_y && bus.s_ready_y) begin
        ez = (k > 127) ? 127 : (k < -128) ? -128 : k;
        es = (k > 127 || k < -128) ? 1 : 0;
        q_z.push_back(exp_z(ez));
        q_s.push_back(exp_s(k, es));
        q_l.push_back(((nacc % 97) == 96) ? 1 : 0);
        nacc++;
        sent++;
      end
      if (bus.m_valid_z && bus.m_ready_z) begin
        if (q_z.size() == 0) begin
          chk("rnd_spurious", 32'(bus.m_valid_z), 0);
        end else begin
          chk("rnd_z", 32'(bus.m_data_out_z), q_z.pop_front());
          chk("rnd_sat", 32'(bus.m_sat_z), q_s.pop_front());
          chk("rnd_last", 32'(bus.m_last_z), q_l.pop_front());
        end
        got++;
      end
      stalled = bus.m_valid_z && !bus.m_ready_z;
      hz = bus.m_data_out_z;
      hs = 32'(bus.m_sat_z);
      hl = 32'(bus.m_last_z);
      @(posedge clk); #1;
      cyc++;
    end
    bus.s_valid_y = 1'b0;
    bus.m_ready_z = 1'b0;
    chk("rnd_count", got, 1000);
    chk("rnd_queue_left", q_z.size(), 0);

    // Mid-frame reset with three entries buffered.
    do_reset();
    stream("pre", 50);
    for (int j = 0; j < 3; j++) begin
      bus.s_valid_y = 1'b1;
      bus.s_data_in_y = ACC_SIZE'((j + 1) * 64);
      @(posedge clk); #1;
    end
    bus.s_valid_y = 1'b0;
    chk("mid_buffered", 32'(bus.m_valid_z), 1);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.m_valid_z), 0);
    chk("mid_rst_z", 32'(bus.m_data_out_z), 0);
    chk("mid_rst_ready", 32'(bus.s_ready_y), 1);
    @(posedge clk); #1 reset = 1'b1;
    stream("post", Y_COUNT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
